ahb_lite_sram_slave: RTL and testbench
======================================

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 The parameter DATA_W SHALL default to 32, be legal at 32 or 64, and set the bus data width.
REQ-002 The parameter ADDR_W SHALL default to 32 and set the haddr width.
REQ-003 The parameter MEM_DEPTH SHALL default to 256 and set the storage depth in DATA_W words (power of two).
REQ-004 The parameter WAIT_STATES SHALL default to 0, be legal at 0..7, and set the number of hreadyout-low cycles per OKAY transfer.
REQ-005 The clock and reset SHALL be hclk (in, 1, single clock, all state on rising edge) and hresetn (in, 1, synchronous active-low reset).
REQ-006 The address-phase inputs SHALL be hsel (in, 1, slave select), haddr (in, ADDR_W, byte address), htrans (in, 2, IDLE=0/BUSY=1/NONSEQ=2/SEQ=3) and hwrite (in, 1, 1=write).
REQ-007 The remaining inputs SHALL be hsize (in, 3, bytes=2^hsize), hburst (in, 3, accepted and ignored), hmastlock (in, 1, ignored), hwdata (in, DATA_W, write data in data phase) and hready (in, 1, bus ready from mux).
REQ-008 The outputs SHALL be hreadyout (out, 1, slave ready), hresp (out, 1, 0=OKAY, 1=ERROR) and hrdata (out, DATA_W, read data).

Function
REQ-009 A transfer SHALL be accepted only on a rising edge with hsel=1, hready=1 and htrans[1]=1, latching haddr, hwrite and hsize.
REQ-010 IDLE or BUSY transfers, or hsel=0, with hready=1 SHALL produce a zero-wait OKAY (hreadyout=1, hresp=0) in the following cycle.
REQ-011 The FSM states SHALL be ST_IDLE, ST_WAIT, ST_ERR1 and ST_ERR2.
REQ-012 On accepting a legal transfer, the FSM SHALL go to ST_WAIT with the counter set to WAIT_STATES, or, when WAIT_STATES=0, remain in or return to ST_IDLE with the data phase completing next cycle.
REQ-013 In ST_WAIT, hreadyout SHALL be 0 and hresp 0, with the counter decrementing each cycle; at count 1 the next cycle SHALL be the final data-phase cycle (hreadyout=1, hresp=0).
REQ-014 A transfer SHALL be illegal if hsize > log2(DATA_W/8), if haddr is not aligned to 2^hsize, or if the word index haddr/(DATA_W/8) >= MEM_DEPTH.
REQ-015 An illegal transfer SHALL give a two-cycle ERROR: ST_ERR1 (hreadyout=0, hresp=1) then ST_ERR2 (hreadyout=1, hresp=1), with no wait states and no memory update.
REQ-016 A transfer accepted during the ST_ERR2 cycle SHALL be processed normally (no further error unless it is itself illegal).
REQ-017 A write SHALL update only the byte lanes selected by hsize and haddr[log2(DATA_W/8)-1:0] (little-endian), sampling hwdata on the final data-phase edge.
REQ-018 Read data SHALL be driven on hrdata during the final data-phase cycle (full word, all lanes), with hrdata=0 in all other cycles.
REQ-019 A read whose address phase coincides with the final data-phase cycle of a write to the same word SHALL return the merged post-write data (forwarding).
REQ-020 hreadyout SHALL be 1 whenever no data phase is pending, and hresp SHALL be 0 except in ST_ERR1 and ST_ERR2.
REQ-021 Storage contents SHALL be preserved across reset and undefined after power-up.

Reset
REQ-022 When hresetn=0 on a rising edge, the block SHALL enter ST_IDLE with the counter 0, hreadyout=1, hresp=0, hrdata=0, and discard any pending transfer without a write.
REQ-023 When reset is asserted mid-wait or mid-error, the outputs SHALL be the reset values on the next cycle.
REQ-024 No transfer SHALL be accepted on an edge where hresetn=0.

Verification
REQ-025 Scenario: WAIT_STATES=0, write 0xDEADBEEF to 0x10 (word), then read 0x10 back-to-back -> hrdata=0xDEADBEEF one cycle after the read address phase, hreadyout always 1.
REQ-026 Scenario: WAIT_STATES=2, read 0x20 -> hreadyout low 2 cycles, then high with hrdata valid, hresp=0.
REQ-027 Scenario: write byte 0xAA at 0x13 over the word 0x11223344 at 0x10 -> read 0x10 returns 0xAA223344.
REQ-028 Scenario: access 0x400 with MEM_DEPTH=256, DATA_W=32 -> hreadyout/hresp = 0/1 then 1/1; a follow-up read of 0x0 is unchanged.
REQ-029 Scenario: halfword access at 0x11 -> ERROR response, no write.
REQ-030 Scenario: hresetn low during the second wait cycle -> next cycle hreadyout=1, hresp=0, hrdata=0, and target memory unchanged.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: single-port word storage with byte-lane writes,
// programmable wait states, two-cycle ERROR response for illegal transfers
// and forwarding of a completing write into a back-to-back read.
module ahb_lite_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic              hmastlock,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);
    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int WORD_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              final_r;     // current cycle is the last data-phase cycle of a legal transfer
    logic              pend_write;
    logic [WORD_W-1:0] pend_word;
    logic [LANES-1:0]  pend_strb;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              accept;
    logic              legal;
    logic [7:0]        size_mask;
    logic [LANES-1:0]  strb;
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] rd_fwd;
    logic              unused_ok;

    // Burst type, lock and the SEQ/NONSEQ distinction do not affect a plain SRAM.
    assign unused_ok = ^{hburst, hmastlock, htrans[0]};

    // Address-phase decode: acceptance, legality, byte strobes and target word
    always_comb begin
        accept    = hresetn && hsel && hready && htrans[1] && hreadyout;
        size_mask = (8'd1 << hsize) - 8'd1;
        legal     = (hsize <= 3'(LANE_W))
                 && ((haddr[LANE_W-1:0] & size_mask[LANE_W-1:0]) == '0)
                 && ((haddr >> LANE_W) < ADDR_W'(MEM_DEPTH));
        word      = haddr[LANE_W +: WORD_W];
        strb      = '0;
        for (int i = 0; i < LANES; i++) begin
            strb[i] = (i >= int'(haddr[LANE_W-1:0]))
                   && (i < int'(haddr[LANE_W-1:0]) + (1 << hsize));
        end
    end

    // Read word for a new address phase, merged with a write completing this edge
    always_comb begin
        rd_fwd = mem[word];
        if (final_r && pend_write && (pend_word == word)) begin
            for (int i = 0; i < LANES; i++) begin
                if (pend_strb[i]) rd_fwd[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    // Storage update on the final data-phase edge of a write; not reset
    always_ff @(posedge hclk) begin
        if (hresetn && final_r && pend_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (pend_strb[i]) mem[pend_word][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    // Transfer FSM with registered bus responses
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hreadyout  <= 1'b1;
            hresp      <= 1'b0;
            hrdata     <= '0;
            final_r    <= 1'b0;
            pend_write <= 1'b0;
            pend_word  <= '0;
            pend_strb  <= '0;
        end else begin
            hrdata  <= '0;
            final_r <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (cnt == 3'd1) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        hreadyout <= 1'b1;
                        final_r   <= 1'b1;
                        if (!pend_write) hrdata <= mem[pend_word];
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    // ST_IDLE and ST_ERR2 both leave the bus ready for a new address phase
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                    if (accept) begin
                        if (!legal) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else begin
                            pend_write <= hwrite;
                            pend_word  <= word;
                            pend_strb  <= strb;
                            if (WAIT_STATES == 0) begin
                                final_r <= 1'b1;
                                if (!hwrite) hrdata <= rd_fwd;
                            end else begin
                                state     <= ST_WAIT;
                                cnt       <= CNT_W'(WAIT_STATES);
                                hreadyout <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (0 and 2 wait states) share one
// bus driver; a transaction-level model with a byte-addressed memory predicts
// every cycle's response, plus directed scenarios with literal expectations.
module tb_ahb_lite_sram_slave;
    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        rdy0, rdy2, resp0, resp2;
    logic [31:0] rdata0, rdata2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
        .hwdata(hwdata), .hready(rdy0), .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0));

    ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
        .hwdata(hwdata), .hready(rdy2), .hreadyout(rdy2), .hresp(resp2), .hrdata(rdata2));

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // kind: 0 no data phase, 1 OKAY transfer, 2 ERROR response
    int         m_kind [2];
    int         m_left [2];   // ready-low cycles still to go in the data phase
    bit         m_wr   [2];
    int         m_addr [2];
    int         m_size [2];
    logic [7:0] mem_b  [2][1024];
    bit         known  [2][1024];

    function automatic int ws(int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic model_step(int k);
        logic [31:0] nb;
        int ba;
        if (!hresetn) begin
            m_kind[k] = 0;
            m_left[k] = 0;
        end else if (m_kind[k] != 0 && m_left[k] > 0) begin
            m_left[k]--;
        end else begin
            if (m_kind[k] == 1 && m_wr[k]) begin
                for (int b = 0; b < (1 << m_size[k]); b++) begin
                    ba = m_addr[k] + b;
                    mem_b[k][ba] = hwdata[8*(ba%4) +: 8];
                    known[k][ba] = 1;
                end
            end
            if (hsel && htrans[1]) begin
                nb = 32'd1 << hsize;
                if (hsize > 3'd2 || (haddr & (nb - 32'd1)) != 0 || haddr >= 32'd1024) begin
                    m_kind[k] = 2;
                    m_left[k] = 1;
                end else begin
                    m_kind[k] = 1;
                    m_left[k] = ws(k);
                    m_wr[k]   = hwrite;
                    m_addr[k] = int'(haddr);
                    m_size[k] = int'(hsize);
                end
            end else begin
                m_kind[k] = 0;
            end
        end
    endtask

    function automatic void exp_out(int k, output logic r, output logic e,
                                    output logic [31:0] d, output logic [31:0] m);
        int base;
        r = (m_kind[k] == 0) || (m_left[k] == 0);
        e = (m_kind[k] == 2);
        d = '0;
        m = '1;
        if (m_kind[k] == 1 && m_left[k] == 0 && !m_wr[k]) begin
            base = m_addr[k] & ~3;
            for (int b = 0; b < 4; b++) begin
                d[8*b +: 8] = mem_b[k][base+b];
                m[8*b +: 8] = known[k][base+b] ? 8'hFF : 8'h00;
            end
        end
    endfunction

    // Model advances on the same edge the DUTs sample their inputs
    always @(posedge hclk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // Compare both instances against the model mid-cycle
    logic        er, ee;
    logic [31:0] ed, em;
    always @(negedge hclk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                exp_out(k, er, ee, ed, em);
                check($sformatf("model hreadyout[%0d]", k), 32'(k == 0 ? rdy0 : rdy2), 32'(er));
                check($sformatf("model hresp[%0d]", k), 32'(k == 0 ? resp0 : resp2), 32'(ee));
                check($sformatf("model hrdata[%0d]", k), (k == 0 ? rdata0 : rdata2) & em, ed & em);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        c_rdy  [2][4];
    logic        c_resp [2][4];
    logic [31:0] c_dat  [2][4];

    task automatic cyc();
        @(negedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'd0;
    endtask

    // One transfer followed by four idle cycles; captures responses of both instances
    task automatic xfer(logic [31:0] a, logic wr, logic [2:0] sz, logic [31:0] wd);
        hsel = 1'b1; htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz; hwdata = wd;
        cyc();
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            c_rdy[0][i] = rdy0;  c_resp[0][i] = resp0; c_dat[0][i] = rdata0;
            c_rdy[1][i] = rdy2;  c_resp[1][i] = resp2; c_dat[1][i] = rdata2;
            cyc();
        end
    endtask

    logic [31:0] mw;

    initial begin
        hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'd0; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hmastlock = 1'b0; hwdata = '0;
        repeat (2) cyc();
        hresetn = 1'b1;
        chk_en  = 1;
        check("reset hreadyout0", 32'(rdy0), 32'd1);
        check("reset hreadyout2", 32'(rdy2), 32'd1);
        check("reset hresp0", 32'(resp0), 32'd0);
        check("reset hresp2", 32'(resp2), 32'd0);
        check("reset hrdata0", rdata0, 32'd0);
        check("reset hrdata2", rdata2, 32'd0);

        // Back-to-back write then read of 0x10 on the zero-wait instance
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
        cyc();
        hwrite = 1'b0; hwdata = 32'hDEADBEEF;
        check("b2b write-phase hreadyout0", 32'(rdy0), 32'd1);
        cyc();
        idle_bus();
        check("b2b forwarded hrdata0", rdata0, 32'hDEADBEEF);
        check("b2b read-phase hreadyout0", 32'(rdy0), 32'd1);
        repeat (4) cyc();

        // Two wait states on a read
        xfer(32'h20, 1'b1, 3'd2, 32'h5A5A1234);
        xfer(32'h20, 1'b0, 3'd2, 32'h0);
        check("ws2 wait1 hreadyout", 32'(c_rdy[1][0]), 32'd0);
        check("ws2 wait2 hreadyout", 32'(c_rdy[1][1]), 32'd0);
        check("ws2 final hreadyout", 32'(c_rdy[1][2]), 32'd1);
        check("ws2 final hresp", 32'(c_resp[1][2]), 32'd0);
        check("ws2 final hrdata", c_dat[1][2], 32'h5A5A1234);
        check("ws2 wait hrdata zero", c_dat[1][1], 32'h0);
        check("ws0 read hrdata", c_dat[0][0], 32'h5A5A1234);
        check("ws0 after read hrdata zero", c_dat[0][1], 32'h0);

        // Byte write into the middle of a known word
        xfer(32'h10, 1'b1, 3'd2, 32'h11223344);
        xfer(32'h13, 1'b1, 3'd0, 32'hAA000000);
        xfer(32'h10, 1'b0, 3'd2, 32'h0);
        check("byte merge ws0", c_dat[0][0], 32'hAA223344);
        check("byte merge ws2", c_dat[1][2], 32'hAA223344);
        mw = {mem_b[0][19], mem_b[0][18], mem_b[0][17], mem_b[0][16]};
        check("model byte merge", mw, 32'hAA223344);

        // Out-of-range access: error, and word 0 untouched
        xfer(32'h0, 1'b1, 3'd2, 32'hCAFEF00D);
        xfer(32'h400, 1'b1, 3'd2, 32'h99999999);
        check("range err c0 hreadyout0", 32'(c_rdy[0][0]), 32'd0);
        check("range err c0 hresp0", 32'(c_resp[0][0]), 32'd1);
        check("range err c1 hreadyout0", 32'(c_rdy[0][1]), 32'd1);
        check("range err c1 hresp0", 32'(c_resp[0][1]), 32'd1);
        check("range err c2 hresp0", 32'(c_resp[0][2]), 32'd0);
        check("range err c0 hreadyout2", 32'(c_rdy[1][0]), 32'd0);
        check("range err c1 hresp2", 32'(c_resp[1][1]), 32'd1);
        xfer(32'h0, 1'b0, 3'd2, 32'h0);
        check("range word0 ws0", c_dat[0][0], 32'hCAFEF00D);
        check("range word0 ws2", c_dat[1][2], 32'hCAFEF00D);

        // Misaligned halfword write: error, no update
        xfer(32'h11, 1'b1, 3'd1, 32'hFFFFFFFF);
        check("misalign hresp c0", 32'(c_resp[0][0]), 32'd1);
        check("misalign hreadyout c1", 32'(c_rdy[0][1]), 32'd1);
        xfer(32'h10, 1'b0, 3'd2, 32'h0);
        check("misalign no write ws0", c_dat[0][0], 32'hAA223344);
        check("misalign no write ws2", c_dat[1][2], 32'hAA223344);

        // Reset during the second wait cycle of a write
        xfer(32'h30, 1'b1, 3'd2, 32'h01020304);
        hsel = 1'b1; htrans = 2'd2; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
        cyc();
        idle_bus();
        hwdata = 32'hFFFFFFFF;
        cyc();
        hresetn = 1'b0;
        cyc();
        hresetn = 1'b1;
        check("mid-wait reset hreadyout2", 32'(rdy2), 32'd1);
        check("mid-wait reset hresp2", 32'(resp2), 32'd0);
        check("mid-wait reset hrdata2", rdata2, 32'd0);
        cyc();
        xfer(32'h30, 1'b0, 3'd2, 32'h0);
        check("mid-wait reset mem ws2", c_dat[1][2], 32'h01020304);
        check("write before reset ws0", c_dat[0][0], 32'hFFFFFFFF);

        // Randomized traffic; inputs change every cycle, resets occasionally
        for (int n = 0; n < 3000; n++) begin
            hsel      = ($urandom_range(0, 3) != 0);
            htrans    = 2'($urandom_range(0, 3));
            hwrite    = 1'($urandom_range(0, 1));
            hsize     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            haddr     = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 2047)) : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0) haddr = haddr & ~((32'd1 << hsize) - 32'd1);
            hwdata    = $urandom;
            hburst    = 3'($urandom_range(0, 7));
            hmastlock = 1'($urandom_range(0, 1));
            hresetn   = ($urandom_range(0, 99) != 0);
            cyc();
        end
        hresetn = 1'b1;
        idle_bus();
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
